// File: rtl/subtractor_n_bit_if.sv
// Operand/result bundle for the registered N-bit subtractor.
// Carries the zero flag only when SUB_ZERO_FLAG_EN is defined.
interface subtractor_n_bit_if #(
  parameter int N = 4
);
  logic         in_valid;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic         out_valid;
  logic [N-1:0] out;
  logic         cout;
  logic         negative;
`ifdef SUB_ZERO_FLAG_EN
  logic         zero;
`endif

  modport master (
    output in_valid,
    output in_a,
    output in_b,
    input  out_valid,
    input  out,
    input  cout,
`ifdef SUB_ZERO_FLAG_EN
    input  zero,
`endif
    input  negative
  );

  modport slave (
    input  in_valid,
    input  in_a,
    input  in_b,
    output out_valid,
    output out,
    output cout,
`ifdef SUB_ZERO_FLAG_EN
    output zero,
`endif
    output negative
  );
endinterface

// File: rtl/subtractor_n_bit.sv
// Registered N-bit unsigned subtractor: out = a - b as a + ~b + 1 over a ripple chain.
// Optional registered zero flag compiled in with SUB_ZERO_FLAG_EN.
module subtractor_n_bit #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  subtractor_n_bit_if.slave    bus
);

  logic [N:0]   carry;
  logic [N-1:0] b_inv;
  logic [N-1:0] diff;

  assign b_inv    = ~bus.in_b;
  // Carry-in of 1 completes the two's-complement negation of in_b.
  assign carry[0] = 1'b1;

  genvar i;
  generate
    for (i = 0; i < N; i++) begin : g_ripple
      assign diff[i]    = bus.in_a[i] ^ b_inv[i] ^ carry[i];
      assign carry[i+1] = (bus.in_a[i] & b_inv[i]) |
                          (bus.in_a[i] & carry[i]) |
                          (b_inv[i]    & carry[i]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out       <= '0;
      bus.cout      <= 1'b0;
      bus.negative  <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.out      <= diff;
        bus.cout     <= carry[N];
        bus.negative <= ~carry[N];
      end
    end
  end

`ifdef SUB_ZERO_FLAG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.zero <= 1'b0;
    end else if (bus.in_valid) begin
      bus.zero <= ~|diff;
    end
  end
`endif

endmodule

// File: tb/tb_subtractor_n_bit.sv
// Directed-vector bench for subtractor_n_bit at N=4.
// Zero-flag checks are included when SUB_ZERO_FLAG_EN is defined.
module tb_subtractor_n_bit;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  subtractor_n_bit_if #(.N(N)) bus ();

  subtractor_n_bit #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply operands, clock once, then compare all outputs 1 time unit after the edge.
  task automatic vec(input string tag, input logic r, input logic v,
                     input logic [N-1:0] a, input logic [N-1:0] b,
                     input logic exp_valid, input logic [N-1:0] exp_out,
                     input logic exp_cout, input logic exp_neg, input logic exp_zero);
    rst          = r;
    bus.in_valid = v;
    bus.in_a     = a;
    bus.in_b     = b;
    @(posedge clk);
    #1;
    check({tag, ".valid"}, 64'(bus.out_valid), 64'(exp_valid));
    check({tag, ".out"},   64'(bus.out),       64'(exp_out));
    check({tag, ".cout"},  64'(bus.cout),      64'(exp_cout));
    check({tag, ".neg"},   64'(bus.negative),  64'(exp_neg));
`ifdef SUB_ZERO_FLAG_EN
    check({tag, ".zero"},  64'(bus.zero),      64'(exp_zero));
`else
    if (exp_zero === 1'bx) check({tag, ".zero_unused"}, 64'(exp_zero), 64'(1'b0));
`endif
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_a     = '0;
    bus.in_b     = '0;
    #1;

    //        tag        rst  v    a      b      valid out     cout neg  zero
    vec("rst0",     1'b1, 1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    vec("rst1",     1'b1, 1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    vec("0-0",      1'b0, 1'b1, 4'd0,  4'd0,  1'b1, 4'h0, 1'b1, 1'b0, 1'b1);
    vec("1-0",      1'b0, 1'b1, 4'd1,  4'd0,  1'b1, 4'h1, 1'b1, 1'b0, 1'b0);
    vec("1-1",      1'b0, 1'b1, 4'd1,  4'd1,  1'b1, 4'h0, 1'b1, 1'b0, 1'b1);
    vec("3-4",      1'b0, 1'b1, 4'd3,  4'd4,  1'b1, 4'hF, 1'b0, 1'b1, 1'b0);
    vec("8-3",      1'b0, 1'b1, 4'd8,  4'd3,  1'b1, 4'h5, 1'b1, 1'b0, 1'b0);
    vec("2-9",      1'b0, 1'b1, 4'd2,  4'd9,  1'b1, 4'h9, 1'b0, 1'b1, 1'b0);
    vec("15-15",    1'b0, 1'b1, 4'd15, 4'd15, 1'b1, 4'h0, 1'b1, 1'b0, 1'b1);
    vec("0-15",     1'b0, 1'b1, 4'd0,  4'd15, 1'b1, 4'h1, 1'b0, 1'b1, 1'b0);
    vec("15-0",     1'b0, 1'b1, 4'd15, 4'd0,  1'b1, 4'hF, 1'b1, 1'b0, 1'b0);
    vec("12-5",     1'b0, 1'b1, 4'd12, 4'd5,  1'b1, 4'h7, 1'b1, 1'b0, 1'b0);
    // Idle cycle: results hold 12-5 with out_valid low, operands on the bus are ignored.
    vec("idle",     1'b0, 1'b0, 4'd6,  4'd1,  1'b0, 4'h7, 1'b1, 1'b0, 1'b0);
    vec("rst_9-2",  1'b1, 1'b1, 4'd9,  4'd2,  1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    vec("post_rst", 1'b0, 1'b0, 4'd9,  4'd2,  1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    vec("post_rst2",1'b0, 1'b0, 4'd0,  4'd0,  1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    vec("4-4",      1'b0, 1'b1, 4'd4,  4'd4,  1'b1, 4'h0, 1'b1, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish before 100000");
    $fatal(1);
  end
endmodule
